// File: rtl/gcn_argmax_pkg.sv
// Shared types and helpers for the streaming row-wise argmax engine.
// Holds the scan FSM state encoding, the address-width helper used to size
// row/column indices, and the score comparison used by the reduction.
package gcn_argmax_pkg;

    // Scan walk: wait for start, issue row reads, drain the last captured row.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LAST = 2'd2
    } state_e;

    // Common comparison width: one bit wider than the widest supported score
    // (64 bits), so both sign- and zero-extended operands compare correctly.
    localparam int CMP_W = 65;

    // ceil(log2(n)), but never less than 1 so a degenerate size still gets a
    // usable one-bit index.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(n)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Strict greater-than on operands already widened to CMP_W bits.
    // Callers sign-extend in signed mode and zero-extend otherwise.
    function automatic logic gt(input logic [CMP_W-1:0] a,
                                input logic [CMP_W-1:0] b,
                                input logic             signed_mode);
        if (signed_mode) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

endpackage

// File: rtl/argmax_stream_if.sv
// Bundle of the argmax engine's control, score-buffer read port and result
// arrays. The engine sits on the slave modport; the surrounding system
// (score buffer plus whoever kicks off a run) sits on the master modport.
interface argmax_stream_if
    import gcn_argmax_pkg::*;
#(
    parameter int FEATURE_ROWS = 6,
    parameter int COLS         = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int ROW_AW       = clog2_min1(FEATURE_ROWS),
    parameter int IDX_W        = clog2_min1(COLS)
);

    logic                                    start;
    logic                                    rd_en;
    logic [ROW_AW-1:0]                       rd_row;
    logic [COLS-1:0][DATA_WIDTH-1:0]         row_data;
    logic                                    busy;
    logic                                    done;
    logic [FEATURE_ROWS-1:0][IDX_W-1:0]      max_idx;
    logic [FEATURE_ROWS-1:0][DATA_WIDTH-1:0] max_val;

    modport master (
        output start,
        output row_data,
        input  rd_en,
        input  rd_row,
        input  busy,
        input  done,
        input  max_idx,
        input  max_val
    );

    modport slave (
        input  start,
        input  row_data,
        output rd_en,
        output rd_row,
        output busy,
        output done,
        output max_idx,
        output max_val
    );

endinterface

// File: rtl/argmax_reduce.sv
// Combinational argmax over one row of COLS scores.
// Linear scan from column 0 upward with a strict greater-than, so the first
// (lowest-index) occurrence of the maximum wins and an all-equal row yields 0.
// DATA_WIDTH must not exceed 64 so the widened compare keeps a spare bit.
module argmax_reduce
    import gcn_argmax_pkg::*;
#(
    parameter int COLS        = 3,
    parameter int DATA_WIDTH  = 16,
    parameter int SIGNED_MODE = 0,
    parameter int IDX_W       = clog2_min1(COLS)
) (
    input  logic [COLS-1:0][DATA_WIDTH-1:0] scores_i,
    output logic [IDX_W-1:0]                idx_o,
    output logic [DATA_WIDTH-1:0]           val_o
);

    localparam logic IS_SIGNED = (SIGNED_MODE != 0);

    logic [IDX_W-1:0]      best_idx_s;
    logic [DATA_WIDTH-1:0] best_val_s;

    // Extend a raw score to the common compare width in the selected mode.
    function automatic logic [CMP_W-1:0] widen(input logic [DATA_WIDTH-1:0] v);
        return {{(CMP_W - DATA_WIDTH){IS_SIGNED & v[DATA_WIDTH-1]}}, v};
    endfunction

    // Running maximum across the row; a later column replaces the champion
    // only when strictly larger, which keeps ties on the lowest index.
    always_comb begin
        best_idx_s = {IDX_W{1'b0}};
        best_val_s = scores_i[0];
        for (int c = 1; c < COLS; c++) begin
            if (gt(widen(scores_i[c]), widen(best_val_s), IS_SIGNED)) begin
                best_idx_s = IDX_W'(c);
                best_val_s = scores_i[c];
            end else begin
                best_idx_s = best_idx_s;
                best_val_s = best_val_s;
            end
        end
    end

    assign idx_o = best_idx_s;
    assign val_o = best_val_s;

endmodule

// File: rtl/argmax_stream.sv
// Row-wise argmax engine for the GCN output stage.
// On start it reads rows 0..FEATURE_ROWS-1 from a one-cycle-latency score
// buffer, reduces each returned row to (index, value) and stores it in the
// result arrays. done pulses for one cycle once the last row is stored;
// results then hold until rows are overwritten by a later run.
module argmax_stream
    import gcn_argmax_pkg::*;
#(
    parameter int FEATURE_ROWS = 6,
    parameter int COLS         = 3,
    parameter int DATA_WIDTH   = 16,
    parameter int SIGNED_MODE  = 0,
    parameter int ROW_AW       = clog2_min1(FEATURE_ROWS),
    parameter int IDX_W        = clog2_min1(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    argmax_stream_if.slave bus
);

    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(FEATURE_ROWS - 1);

    state_e                                  state_q;
    state_e                                  state_d;
    logic                                    rd_en_q;
    logic                                    rd_en_d;
    logic [ROW_AW-1:0]                       rd_row_q;
    logic [ROW_AW-1:0]                       rd_row_d;
    logic                                    busy_q;
    logic                                    busy_d;
    logic                                    done_q;
    logic                                    done_d;

    // Read strobe/address delayed by one cycle to line up with row_data.
    logic                                    cap_en_q;
    logic [ROW_AW-1:0]                       cap_row_q;

    logic [FEATURE_ROWS-1:0][IDX_W-1:0]      max_idx_q;
    logic [FEATURE_ROWS-1:0][DATA_WIDTH-1:0] max_val_q;

    logic [IDX_W-1:0]                        red_idx_s;
    logic [DATA_WIDTH-1:0]                   red_val_s;

    argmax_reduce #(
        .COLS        (COLS),
        .DATA_WIDTH  (DATA_WIDTH),
        .SIGNED_MODE (SIGNED_MODE),
        .IDX_W       (IDX_W)
    ) u_reduce (
        .scores_i (bus.row_data),
        .idx_o    (red_idx_s),
        .val_o    (red_val_s)
    );

    // Next-state and next-output decode for the IDLE -> READ -> LAST walk;
    // rd_row doubles as the row counter and parks at zero outside READ.
    always_comb begin
        state_d  = state_q;
        rd_en_d  = 1'b0;
        rd_row_d = rd_row_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_READ;
                    rd_en_d  = 1'b1;
                    rd_row_d = {ROW_AW{1'b0}};
                    busy_d   = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                    rd_row_d = {ROW_AW{1'b0}};
                    busy_d   = 1'b0;
                end
            end
            ST_READ: begin
                busy_d = 1'b1;
                if (rd_row_q == LAST_ROW) begin
                    state_d  = ST_LAST;
                    rd_en_d  = 1'b0;
                    rd_row_d = {ROW_AW{1'b0}};
                end else begin
                    state_d  = ST_READ;
                    rd_en_d  = 1'b1;
                    rd_row_d = rd_row_q + ROW_AW'(1);
                end
            end
            ST_LAST: begin
                // The final row is captured on this edge, so done and the
                // last result become visible together.
                state_d  = ST_IDLE;
                rd_row_d = {ROW_AW{1'b0}};
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                rd_row_d = {ROW_AW{1'b0}};
                busy_d   = 1'b0;
            end
        endcase
    end

    // FSM state and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_en_q  <= 1'b0;
            rd_row_q <= {ROW_AW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_en_q  <= rd_en_d;
            rd_row_q <= rd_row_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Capture qualifier: marks the cycle in which row_data belongs to cap_row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_en_q  <= 1'b0;
            cap_row_q <= {ROW_AW{1'b0}};
        end else begin
            cap_en_q  <= rd_en_q;
            cap_row_q <= rd_row_q;
        end
    end

    // Result arrays: only the entry addressed by cap_row is written; all
    // other entries hold, so stale results persist until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_idx_q <= {(FEATURE_ROWS * IDX_W){1'b0}};
            max_val_q <= {(FEATURE_ROWS * DATA_WIDTH){1'b0}};
        end else begin
            for (int r = 0; r < FEATURE_ROWS; r++) begin
                if (cap_en_q && (cap_row_q == ROW_AW'(r))) begin
                    max_idx_q[r] <= red_idx_s;
                    max_val_q[r] <= red_val_s;
                end else begin
                    max_idx_q[r] <= max_idx_q[r];
                    max_val_q[r] <= max_val_q[r];
                end
            end
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_row  = rd_row_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.max_idx = max_idx_q;
    assign bus.max_val = max_val_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: default unsigned 6x3x16 instance, a
// signed 6x3x16 instance and a 10x5x8 instance fed with generated rows.
module tb_argmax_stream;
    import gcn_argmax_pkg::*;

    localparam int NA = 6;
    localparam int CA = 3;
    localparam int WA = 16;
    localparam int NP = 10;
    localparam int CP = 5;
    localparam int WP = 8;
    localparam int IP = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    argmax_stream_if #(.FEATURE_ROWS(NA), .COLS(CA), .DATA_WIDTH(WA)) ifa ();
    argmax_stream_if #(.FEATURE_ROWS(NA), .COLS(CA), .DATA_WIDTH(WA)) ifs ();
    argmax_stream_if #(.FEATURE_ROWS(NP), .COLS(CP), .DATA_WIDTH(WP)) ifp ();

    argmax_stream #(.FEATURE_ROWS(NA), .COLS(CA), .DATA_WIDTH(WA), .SIGNED_MODE(0))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    argmax_stream #(.FEATURE_ROWS(NA), .COLS(CA), .DATA_WIDTH(WA), .SIGNED_MODE(1))
        u_dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs));
    argmax_stream #(.FEATURE_ROWS(NP), .COLS(CP), .DATA_WIDTH(WP), .SIGNED_MODE(0))
        u_dut_p (.clk(clk), .rst_n(rst_n), .bus(ifp));

    logic [CA-1:0][WA-1:0] mem_a [NA];
    logic [CA-1:0][WA-1:0] mem_s [NA];
    logic [CP-1:0][WP-1:0] mem_p [NP];

    // Score buffers: one-cycle read latency.
    always @(posedge clk) if (ifa.rd_en) ifa.row_data <= mem_a[ifa.rd_row];
    always @(posedge clk) if (ifs.rd_en) ifs.row_data <= mem_s[ifs.rd_row];
    always @(posedge clk) if (ifp.rd_en) ifp.row_data <= mem_p[ifp.rd_row];

    int rd_log_a[$];
    int done_log_a[$];

    // Log issued row addresses and done cycles of the default instance.
    always @(negedge clk) begin
        if (ifa.rd_en) rd_log_a.push_back(int'(ifa.rd_row));
        if (ifa.done)  done_log_a.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_a(input int r, input int v0, input int v1, input int v2);
        mem_a[r][0] = 16'(v0);
        mem_a[r][1] = 16'(v1);
        mem_a[r][2] = 16'(v2);
    endtask

    task automatic load_s(input int r, input int v0, input int v1, input int v2);
        mem_s[r][0] = 16'(v0);
        mem_s[r][1] = 16'(v1);
        mem_s[r][2] = 16'(v2);
    endtask

    task automatic load_basic_a();
        load_a(0, 5, 9, 2);
        load_a(1, 7, 1, 3);
        load_a(2, 0, 0, 8);
        load_a(3, 4, 4, 1);
        load_a(4, 1, 6, 6);
        load_a(5, 3, 2, 1);
    endtask

    task automatic clear_logs_a();
        rd_log_a.delete();
        done_log_a.delete();
    endtask

    // Launch one run on the default instance; c0 is the cycle stamp of the start edge.
    task automatic start_a(output int c0);
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        ifa.start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ifa.done) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic chk_rows_a(input string tag, input int ei[NA], input int ev[NA]);
        for (int r = 0; r < NA; r++) begin
            chk($sformatf("%s_idx%0d", tag, r), 128'(ifa.max_idx[r]), 128'(ei[r]));
            chk($sformatf("%s_val%0d", tag, r), 128'(ifa.max_val[r]), 128'(ev[r]));
        end
    endtask

    task automatic chk_seq_a(input string tag, input int n);
        chk({tag, "_rd_count"}, 128'(rd_log_a.size()), 128'(n));
        for (int r = 0; r < rd_log_a.size() && r < n; r++) begin
            chk($sformatf("%s_rd_row%0d", tag, r), 128'(rd_log_a[r]), 128'(r % NA));
        end
    endtask

    initial begin
        int c0;
        int t;
        int nd;
        int found;
        int ei_basic[NA] = '{1, 0, 2, 0, 1, 0};
        int ev_basic[NA] = '{9, 7, 8, 4, 6, 3};
        int ei_ties[NA]  = '{0, 1, 2, 0, 0, 0};
        int ev_ties[NA]  = '{10, 7, 9, 0, 8, 16'hFFFF};
        int ei_sgn[NA]   = '{1, 2, 0, 0, 0, 2};
        int ev_sgn[NA]   = '{1, 16'hFFFE, 5, 16'h7FFF, 16'hFFFF, 16'h8001};
        logic [NP-1:0][IP-1:0] exp_idx_p;
        logic [NP-1:0][WP-1:0] exp_val_p;

        ifa.start = 1'b0;
        ifs.start = 1'b0;
        ifp.start = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rd_en",   128'(ifa.rd_en),  128'd0);
        chk("rst_rd_row",  128'(ifa.rd_row), 128'd0);
        chk("rst_busy",    128'(ifa.busy),   128'd0);
        chk("rst_done",    128'(ifa.done),   128'd0);
        chk("rst_max_idx", 128'(ifa.max_idx), 128'd0);
        chk("rst_max_val", 128'(ifa.max_val), 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic run
        load_basic_a();
        clear_logs_a();
        start_a(c0);
        chk("basic_busy", 128'(ifa.busy), 128'd1);
        wait_done_a(20, t);
        chk("basic_latency", 128'(t - c0), 128'd7);
        chk_rows_a("basic", ei_basic, ev_basic);
        repeat (3) @(negedge clk);
        chk("basic_done_pulses", 128'(done_log_a.size()), 128'd1);
        chk("basic_busy_after", 128'(ifa.busy), 128'd0);
        chk_seq_a("basic", NA);

        // Ties and high-bit values compared unsigned
        load_a(0, 10, 10, 10);
        load_a(1, 2, 7, 7);
        load_a(2, 3, 3, 9);
        load_a(3, 0, 0, 0);
        load_a(4, 8, 1, 8);
        load_a(5, 16'hFFFF, 16'h0001, 16'h8000);
        clear_logs_a();
        start_a(c0);
        wait_done_a(20, t);
        chk("ties_latency", 128'(t - c0), 128'd7);
        chk_rows_a("ties", ei_ties, ev_ties);

        // Signed instance
        load_s(0, 16'hFFFF, 16'h0001, 16'h8000);
        load_s(1, 16'h8000, 16'h8001, 16'hFFFE);
        load_s(2, 16'h0005, 16'hFFFB, 16'h0005);
        load_s(3, 16'h7FFF, 16'h8000, 16'h0000);
        load_s(4, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        load_s(5, 16'h8000, 16'h8000, 16'h8001);
        @(negedge clk);
        ifs.start = 1'b1;
        @(posedge clk);
        #1 ifs.start = 1'b0;
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifs.done) begin
                t = i;
                break;
            end
        end
        chk("sgn_latency", 128'(t), 128'd7);
        for (int r = 0; r < NA; r++) begin
            chk($sformatf("sgn_idx%0d", r), 128'(ifs.max_idx[r]), 128'(ei_sgn[r]));
            chk($sformatf("sgn_val%0d", r), 128'(ifs.max_val[r]), 128'(ev_sgn[r]));
        end

        // start pulses during a run are ignored
        load_basic_a();
        clear_logs_a();
        start_a(c0);
        @(negedge clk);
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1 ifa.start = 1'b0;
        wait_done_a(20, t);
        chk("hs_latency", 128'(t - c0), 128'd7);
        repeat (12) @(negedge clk);
        chk("hs_done_pulses", 128'(done_log_a.size()), 128'd1);
        chk_seq_a("hs", NA);
        chk_rows_a("hs", ei_basic, ev_basic);

        // start held high: a new run every N+2 cycles
        clear_logs_a();
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1 c0 = cyc;
        nd = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ifa.done) nd++;
            if (nd == 3) break;
        end
        ifa.start = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_done_pulses", 128'(done_log_a.size()), 128'd3);
        for (int k = 0; k < done_log_a.size() && k < 3; k++) begin
            chk($sformatf("held_done_cyc%0d", k), 128'(done_log_a[k] - c0), 128'(7 + 8 * k));
        end
        chk_seq_a("held", 3 * NA);

        // Asynchronous reset in the middle of READ
        clear_logs_a();
        start_a(c0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (ifa.rd_en && ifa.rd_row == 3'd3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_reached_row3", 128'(found), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_en",   128'(ifa.rd_en),   128'd0);
        chk("midrst_busy",    128'(ifa.busy),    128'd0);
        chk("midrst_done",    128'(ifa.done),    128'd0);
        chk("midrst_max_idx", 128'(ifa.max_idx), 128'd0);
        chk("midrst_max_val", 128'(ifa.max_val), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_a(c0);
        wait_done_a(20, t);
        chk("recover_latency", 128'(t - c0), 128'd7);
        chk_rows_a("recover", ei_basic, ev_basic);

        // 10x5x8 instance against a reference argmax
        for (int run = 0; run < 200; run++) begin
            int mx;
            mx = ((run % 2) == 0) ? 3 : 255;
            for (int r = 0; r < NP; r++) begin
                int bi;
                logic [WP-1:0] bv;
                for (int c = 0; c < CP; c++) begin
                    mem_p[r][c] = 8'($urandom_range(0, mx));
                end
                bi = 0;
                bv = mem_p[r][0];
                for (int c = 1; c < CP; c++) begin
                    if (mem_p[r][c] > bv) begin
                        bi = c;
                        bv = mem_p[r][c];
                    end
                end
                exp_idx_p[r] = 3'(bi);
                exp_val_p[r] = bv;
            end
            @(negedge clk);
            ifp.start = 1'b1;
            @(posedge clk);
            #1 ifp.start = 1'b0;
            t = -1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (ifp.done) begin
                    t = i;
                    break;
                end
            end
            chk($sformatf("par%0d_latency", run), 128'(t), 128'd11);
            chk($sformatf("par%0d_idx", run), 128'(ifp.max_idx), 128'(exp_idx_p));
            chk($sformatf("par%0d_val", run), 128'(ifp.max_val), 128'(exp_val_p));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
Parametrised row-wise argmax engine for the GCN output stage.
- Once the combination stage completes, it walks FEATURE_ROWS rows of a COLS-wide score matrix through a one-cycle-latency read port.
- For each row it records the column index of the maximum value, and that maximum value.
- Outputs: one-cycle done pulse, with a result array that holds until the next run.
- Generalises the fixed 6x3 unsigned argmax with: width/depth/column parametrisation, a signed mode, deterministic tie-break, an explicit start/busy handshake, and the block driving its own read addresses.

Parameters:
FEATURE_ROWS, 6, number of rows scanned per run (>=1)
COLS, 3, scores per row (>=2)
DATA_WIDTH, 16, width of each score
SIGNED_MODE, 0, 1 = compare as two's complement, 0 = unsigned
ROW_AW, $clog2(FEATURE_ROWS) (min 1), row address width
IDX_W, $clog2(COLS) (min 1), column index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  run request; sampled only in IDLE
rd_en  out  1  read strobe to the score buffer
rd_row  out  ROW_AW  row address for rd_en
row_data  in  COLS x DATA_WIDTH  scores of the requested row; valid the cycle after rd_en
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when all results are written
max_idx  out  FEATURE_ROWS x IDX_W  per-row argmax column index
max_val  out  FEATURE_ROWS x DATA_WIDTH  per-row maximum score

Behaviour:
- Reset (rst=0, any time, including mid-run):
  - state IDLE; rd_en=0, rd_row=0, busy=0, done=0.
  - All max_idx and max_val entries = 0; internal row counters = 0.
  - Effect is immediate (asynchronous); the first active edge after rst rises is a normal IDLE edge.
- State machine: IDLE -> READ -> LAST -> IDLE.
  - IDLE: start=1 at edge E0 -> READ; busy=1.
  - READ: rd_en=1 with rd_row = 0,1,...,FEATURE_ROWS-1 on consecutive cycles (FEATURE_ROWS cycles). The edge that ends the cycle issuing row FEATURE_ROWS-1 moves the FSM to LAST.
  - LAST: rd_en=0. The edge ending this cycle writes the final row, sets done=1 and busy=0, and returns to IDLE.
- Capture pipeline:
  - A delayed copy of rd_en/rd_row (cap_en/cap_row) qualifies row_data.
  - At each edge with cap_en=1: max_idx[cap_row] and max_val[cap_row] are written from the reduce result.
  - No other entries change.
- Latency: done is high during cycle N+1 after E0 (N = FEATURE_ROWS). The final results are visible in that same cycle.
- Compare rule:
  - Strict greater-than, scanning from column 0 upward.
  - Ties resolve to the lowest column index; an all-equal row gives index 0.
  - SIGNED_MODE selects signed or unsigned comparison. max_val is the raw bit pattern.
- start:
  - Ignored while busy=1, including the done cycle's edge.
  - A start held high in IDLE after done launches a new run. Back-to-back runs therefore have one IDLE cycle between them.
- Results are not cleared on start. Each entry is overwritten as its row is captured; partially updated arrays are visible while busy=1.
- done stays 0 except for the single pulse cycle.

Decomposition:
- Package gcn_argmax_pkg:
  - state enum (IDLE, READ, LAST);
  - function clog2_min1;
  - compare function gt(a, b, signed_mode).
- Sub-module argmax_reduce (combinational):
  - Inputs: COLS x DATA_WIDTH scores.
  - Outputs: index and value.
  - Implemented as a linear or tree reduction that preserves the lowest-index tie rule.
- The top level holds the FSM, counters, capture pipeline and result registers.

Test Plan:
- Basic, defaults. Rows {5,9,2},{7,1,3},{0,0,8},{4,4,1},{1,6,6},{3,2,1} -> max_idx = {1,0,2,0,1,0}, max_val = {9,7,8,4,6,3}. done exactly 7 cycles after the start edge, single cycle; rd_row sequence 0..5.
- Ties: row {10,10,10} -> idx 0; row {2,7,7} -> idx 1.
- Signed, SIGNED_MODE=1: row {16'hFFFF,16'h0001,16'h8000} -> idx 1, val 1. Same row with SIGNED_MODE=0 -> idx 0, val 16'hFFFF.
- Parametrised, FEATURE_ROWS=10, COLS=5, DATA_WIDTH=8, random data vs reference model over 200 runs -> all indices and values match; done latency 11 cycles.
- Handshake: start pulsed at cycles 2 and 4 of a run -> ignored (single run, rd_rows 0..N-1 once). start held high continuously -> new run every N+2 cycles.
- Reset mid-run: rst low during READ at row 3 -> rd_en, busy, done and all results read 0 immediately. After release, a new start completes normally with correct results.
